// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline definitions.
//   XLEN             datapath width
//   DEFAULT_RESET_PC PC fetched first after reset unless overridden
//   fetch_entry_t    queued fetch result {instr, pc}
//   align_word()     clears the byte-offset bits of an address
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous in-order FIFO of fetch_entry_t.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        empties the queue; wins over push/pop in the same cycle
//   push, push_data  enqueue one entry
//   pop          dequeue the head entry
//   head         current head entry (undefined when count == 0)
//   count        number of buffered entries (0..DEPTH)
module fetch_queue
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = mem[rd_ptr];
  end

  // The fetch credit rule must keep the queue from overflowing.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled RV32I instruction-fetch stage.
// Issues word-aligned requests to a variable-latency instruction memory,
// buffers responses with their PCs, and hands them to IF/ID under
// valid/ready. A redirect from Execute flushes the queue and discards
// every response still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds fetch_misaligned).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data           in-order response, never back-pressured
//   redirect_valid, redirect_pc   taken branch/jump target from Execute
//   fetch_ready                   IF/ID accepts (low = stall)
//   fetch_misaligned              sticky misaligned-redirect flag (macro only)
//   instr_valid, InstrF, PCF, PCPlus4F  queue head toward IF/ID
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_misaligned,
`endif
  output logic            instr_valid,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   q_count;
  logic [CW:0]     credit_used;
  logic            blocked;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
      fetch_misaligned <= 1'b1;
    end
  end
  assign blocked = fetch_misaligned;
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    target      = align_word(redirect_pc);
    // In-flight requests plus buffered entries never exceed the queue size,
    // so every surviving response has a free slot waiting for it.
    credit_used = {1'b0, inflight} + {1'b0, q_count};
    imem_req_valid = !reset && !redirect_valid && !blocked &&
                     (credit_used < (CW+1)'(QUEUE_DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && !redirect_valid && (drop == '0);
    instr_valid    = (q_count != '0);
    pop            = instr_valid && fetch_ready && !redirect_valid;
    push_data.instr = imem_rsp_data;
    push_data.pc    = rsp_pc;
    InstrF   = instr_valid ? head.instr : '0;
    PCF      = instr_valid ? head.pc : '0;
    PCPlus4F = instr_valid ? head.pc + XLEN'(4) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        // Everything still outstanding belongs to the old path; a response
        // landing this very cycle is already being discarded.
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_keep) rsp_pc   <= rsp_pc + XLEN'(4);
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The reference model tracks requests as an in-order memory queue tagged
// with a redirect epoch; a response is delivered only if its epoch is
// current, and deliveries must appear as consecutive PCs from the last
// redirect target. Honours FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_ready   (fetch_ready),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .instr_valid   (instr_valid),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc, epoch, buffered, lat_min, lat_max, last_due, acc_count;
  logic [31:0] exp_head, exp_req;
  bit          misaligned_m;
  bit          last_valid, last_req_valid;
  logic [31:0] last_pcf, last_p4, last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic run_cycle(input bit redir, input logic [31:0] tgt, input bit frdy, input bit rrdy);
    mreq_t       e;
    bit          rsp, exp_valid, exp_rv;
    int unsigned due;
    logic [31:0] t;
    rsp = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
    redirect_valid = redir;
    redirect_pc    = tgt;
    fetch_ready    = frdy;
    imem_req_ready = rrdy;
    #2;
    exp_valid = (buffered != 0);
    exp_rv    = !redir && !misaligned_m && (mq.size() + buffered < DEPTH);
    check_eq("instr_valid", instr_valid, exp_valid);
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check_eq("req_addr", imem_req_addr, exp_req);
    if (exp_valid) begin
      check_eq("PCF", PCF, exp_head);
      check_eq("InstrF", InstrF, mem_word(exp_head));
      check_eq("PCPlus4F", PCPlus4F, exp_head + 32'd4);
    end else begin
      check_eq("PCF_empty", PCF, 32'd0);
      check_eq("InstrF_empty", InstrF, 32'd0);
      check_eq("PCPlus4F_empty", PCPlus4F, 32'd0);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("fetch_misaligned", fetch_misaligned, misaligned_m);
`endif
    last_valid     = instr_valid;
    last_pcf       = PCF;
    last_p4        = PCPlus4F;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    if (exp_valid && frdy && !redir) begin
      buffered--;
      exp_head += 32'd4;
    end
    if (rsp) begin
      e = mq.pop_front();
      if (!redir && e.epoch == epoch) buffered++;
    end
    if (exp_rv && rrdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: exp_req, epoch: epoch, due: due});
      exp_req += 32'd4;
      acc_count++;
    end
    if (redir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) misaligned_m = 1'b1;
      t = tgt & ~32'h3;
`else
      t = tgt & ~32'h3;
`endif
      epoch++;
      buffered = 0;
      exp_head = t;
      exp_req  = t;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b1;
    imem_req_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    check_eq("rst_instr_valid", instr_valid, 32'd0);
    check_eq("rst_req_valid", imem_req_valid, 32'd0);
    check_eq("rst_PCF", PCF, 32'd0);
    check_eq("rst_PCPlus4F", PCPlus4F, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("rst_misaligned", fetch_misaligned, 32'd0);
`endif
    @(posedge clk);
    #1;
    mq.delete();
    epoch++;
    buffered     = 0;
    exp_head     = 32'h0;
    exp_req      = 32'h0;
    misaligned_m = 1'b0;
    cyc          = 0;
    last_due     = 0;
    acc_count    = 0;
    reset        = 1'b0;
  endtask

  initial begin
    bit found;
    epoch   = 0;
    lat_min = 1;
    lat_max = 1;

    // Steady stream, L=1: PCF 0,4,8,... from the third cycle after reset.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (k >= 2) begin
        check_eq("seq_valid", last_valid, 32'd1);
        check_eq("seq_pcf", last_pcf, 32'(4 * (k - 2)));
      end
    end

    // IF/ID stalled: credit caps requests at the queue depth.
    do_reset();
    for (int k = 0; k < 10; k++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("stall_accepts", acc_count, DEPTH);
    check_eq("stall_req_low", last_req_valid, 32'd0);
    check_eq("stall_head_valid", last_valid, 32'd1);
    check_eq("stall_head_pc", last_pcf, 32'h0);

    // L=3, redirect with three requests in flight.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b1, 32'h100, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_valid) begin
        found = 1'b1;
        check_eq("l3_first_pc", last_pcf, 32'h100);
      end
    end
    check_eq("l3_target_seen", found, 32'd1);

    // L=1 redirect coincident with a response: target at N+1, valid at N+3.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b1, 32'h200, 1'b1, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rd_req_valid", last_req_valid, 32'd1);
    check_eq("rd_req_addr", last_req_addr, 32'h200);
    check_eq("rd_n1_empty", last_valid, 32'd0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rd_n2_empty", last_valid, 32'd0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("rd_n3_valid", last_valid, 32'd1);
    check_eq("rd_n3_pc", last_pcf, 32'h200);

    // Address wrap at the top of the address space.
    run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_valid && last_pcf == 32'hFFFF_FFFC) found = 1'b1;
    end
    check_eq("wrap_seen", found, 32'd1);
    check_eq("wrap_pcplus4", last_p4, 32'h0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("wrap_next_pc", last_pcf, 32'h0);

    // Misaligned redirect.
    run_cycle(1'b1, 32'h102, 1'b1, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      check_eq("mis_sticky", fetch_misaligned, 32'd1);
      check_eq("mis_no_req", last_req_valid, 32'd0);
      check_eq("mis_empty", last_valid, 32'd0);
    end
`else
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (last_valid) begin
        found = 1'b1;
        check_eq("mis_forced_pc", last_pcf, 32'h100);
      end
    end
    check_eq("mis_target_seen", found, 32'd1);
`endif

    // Randomized traffic: variable latency, back-pressure, redirects.
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      bit          rd;
      logic [31:0] tg;
      rd = ($urandom_range(99) < 4);
      tg = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      run_cycle(rd, tg, $urandom_range(3) != 0, $urandom_range(3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
